// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the iterative mul/div unit, tracks its pending write, stalls dependent D-stage ops and arbitrates the write port
module muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            muldivD,
  input  logic            regwriteD,
  input  logic [4:0]      rsD,
  input  logic [4:0]      rtD,
  input  logic [4:0]      writeregD,
  input  logic            issueE,
  input  logic [4:0]      writeregE,
  input  logic            regwriteW,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  output logic            unit_start,
  output logic            stall_req,
  output logic            wb_en,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, WB_WAIT = 2'd2;
  logic [1:0] state;
  logic [4:0] pend_rd;
  logic [XLEN-1:0] res;
  logic [3:0] starve_cnt;
  logic idle, active, hit, starved;
  logic [4:0] act_rd;
  always_comb begin
    idle = state == IDLE;
    act_rd = idle ? writeregE : pend_rd;
    active = !idle || issueE;
    hit = act_rd != 5'd0 && (rsD == act_rd || rtD == act_rd || (regwriteD && writeregD == act_rd));
    starved = state == WB_WAIT && starve_cnt >= 4'(STARVE_MAX);
    unit_start = idle && issueE;
    stall_req = active && (hit || muldivD || starved);
    wb_en = state == WB_WAIT && !regwriteW;
    wb_reg = pend_rd;
    wb_data = res;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pend_rd <= 5'd0;
      res <= '0;
      starve_cnt <= 4'd0;
    end else if (unit_start) begin
      pend_rd <= writeregE;
      state <= RUN;
    end else if (state == RUN && unit_done) begin
      state <= pend_rd == 5'd0 ? IDLE : WB_WAIT;
      res <= unit_result;
      starve_cnt <= 4'd0;
    end else if (state == WB_WAIT) begin
      if (wb_en) state <= IDLE;
      else if (starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: timeline-model checks of issue, stall, starvation and writeback behaviour
module tb_muldiv_sequencer;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic muldivD = 1'b0, regwriteD = 1'b0, issueE = 1'b0, regwriteW = 1'b0, unit_done = 1'b0;
  logic [4:0] rsD = '0, rtD = '0, writeregD = '0, writeregE = '0;
  logic [31:0] unit_result = '0;
  logic unit_start, stall_req, wb_en;
  logic [4:0] wb_reg;
  logic [31:0] wb_data;
  int tests = 0, fails = 0, cyc = 0, starts = 0, exp_starts = 0;
  bit op_valid = 1'b0;
  int op_iss = 0, op_lat = 1;
  logic [4:0] op_rd = '0;
  logic [31:0] op_data = '0;
  muldiv_sequencer #(.XLEN(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n), .muldivD(muldivD), .regwriteD(regwriteD),
    .rsD(rsD), .rtD(rtD), .writeregD(writeregD), .issueE(issueE), .writeregE(writeregE),
    .regwriteW(regwriteW), .unit_done(unit_done), .unit_result(unit_result),
    .unit_start(unit_start), .stall_req(stall_req), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  function automatic int wait_n();
    return cyc - (op_iss + op_lat + 1);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask
  task automatic drive(int dmode, int wmode, bit spur);
    int w;
    bit iw, first;
    w = wait_n();
    iw = op_valid && w >= 0;
    first = op_valid && cyc == op_iss;
    issueE = first || (spur && op_valid && $urandom_range(0, 5) == 0);
    writeregE = first ? op_rd : 5'($urandom);
    unit_done = op_valid && cyc == op_iss + op_lat;
    unit_result = unit_done ? op_data : $urandom;
    if (!unit_done && spur && $urandom_range(0, 4) == 0 && (!op_valid || first || iw)) unit_done = 1'b1;
    muldivD = 1'b0; regwriteD = 1'b0; rsD = '0; rtD = '0; writeregD = '0;
    case (dmode)
      1: rsD = op_rd;
      2: begin regwriteD = 1'b1; writeregD = op_rd; end
      3: begin
        muldivD = $urandom_range(0, 3) == 0;
        regwriteD = 1'($urandom);
        rsD = 5'($urandom_range(0, 9));
        rtD = 5'($urandom_range(0, 9));
        writeregD = 5'($urandom_range(0, 9));
      end
      4: muldivD = 1'b1;
      default: ;
    endcase
    regwriteW = wmode == 1 ? !(iw && w >= 6) : wmode == 2 ? 1'($urandom) : 1'b0;
  endtask
  task automatic step();
    int w;
    bit iw, ewb, hit;
    @(negedge clk);
    w = wait_n();
    iw = op_valid && w >= 0;
    ewb = iw && !regwriteW;
    hit = op_rd != 5'd0 && (rsD == op_rd || rtD == op_rd || (regwriteD && writeregD == op_rd));
    chk("unit_start", 32'(unit_start), 32'(op_valid && cyc == op_iss));
    chk("stall_req", 32'(stall_req), 32'(op_valid && (hit || muldivD || (iw && w >= SM))));
    chk("wb_en", 32'(wb_en), 32'(ewb));
    if (ewb) begin
      chk("wb_reg", 32'(wb_reg), 32'(op_rd));
      chk("wb_data", wb_data, op_data);
    end
    if (unit_start) starts++;
    @(posedge clk);
    #1;
    if (ewb || (op_valid && op_rd == 5'd0 && cyc == op_iss + op_lat)) op_valid = 1'b0;
    cyc++;
  endtask
  task automatic begin_op(logic [4:0] rd, int lat);
    op_valid = 1'b1; op_iss = cyc; op_rd = rd; op_lat = lat; op_data = $urandom;
    exp_starts++;
  endtask
  task automatic run_op(logic [4:0] rd, int lat, int dmode, int wmode, bit spur);
    int n;
    begin_op(rd, lat);
    n = 0;
    while (op_valid && n < 200) begin
      drive(dmode, wmode, spur);
      step();
      n++;
    end
    if (op_valid) begin
      chk("op_timeout", 32'(op_valid), 32'd0);
      op_valid = 1'b0;
    end
  endtask
  task automatic idle(int n, int dmode, bit spur);
    repeat (n) begin
      drive(dmode, 0, spur);
      step();
    end
  endtask
  task automatic do_reset(bit done_next);
    reset_n = 1'b0;
    issueE = 1'b0; unit_done = 1'b0; muldivD = 1'b0; regwriteD = 1'b0; regwriteW = 1'b0;
    rsD = '0; rtD = '0; writeregD = '0; writeregE = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    op_valid = 1'b0;
    unit_done = done_next;
    unit_result = $urandom;
    @(negedge clk);
    chk("rst_unit_start", 32'(unit_start), 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;
    unit_done = 1'b0;
    cyc++;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    run_op(5'd5, 8, 0, 0, 1'b0);
    idle(3, 0, 1'b0);
    run_op(5'd5, 4, 1, 0, 1'b0);
    idle(1, 0, 1'b0);
    run_op(5'd5, 3, 2, 0, 1'b0);
    idle(1, 0, 1'b0);
    run_op(5'd9, 2, 0, 1, 1'b0);
    idle(1, 0, 1'b0);
    run_op(5'd6, 3, 4, 0, 1'b0);
    run_op(5'd7, 2, 0, 0, 1'b0);
    idle(2, 3, 1'b1);
    begin_op(5'd7, 2);
    repeat (2) begin
      drive(0, 0, 1'b0);
      step();
    end
    do_reset(1'b1);
    idle(4, 3, 1'b0);
    run_op(5'd0, 3, 3, 2, 1'b0);
    idle(3, 3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_op(5'($urandom), $urandom_range(1, 12), $urandom_range(0, 1) == 0 ? 3 : $urandom_range(0, 4),
             $urandom_range(0, 2), 1'b1);
      idle($urandom_range(0, 3), 3, 1'b1);
    end
    chk("start_count", 32'(starts), 32'(exp_starts));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Controller for the iterative multiply/divide unit in the 5-stage core. It launches the unit when a muldiv instruction reaches Execute and holds that instruction's destination as a single pending write. It produces a stall request, OR'd by the hazard unit into stallF/stallD/flushE, for any D-stage instruction that conflicts with the pending write. It arbitrates the register-file write port with the normal W-stage writeback.

## Interface
- XLEN, 32, data width of unit result
- STARVE_MAX, 4, consecutive W-stage port-busy cycles tolerated before forcing a bubble (1..15)

- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- muldivD  in  1  D-stage instruction is a muldiv op
- regwriteD  in  1  D-stage instruction writes a register
- rsD, rtD, writeregD  in  5 each  D-stage source/destination addresses
- issueE  in  1  valid (non-flushed) muldiv instruction in E this cycle
- writeregE  in  5  its destination register
- regwriteW  in  1  pipeline W stage writes the register file this cycle
- unit_done  in  1  one-cycle pulse, result valid
- unit_result  in  XLEN  unit output, valid with unit_done
- unit_start  out  1  launch pulse to unit (operands come from E-stage bypass muxes)
- stall_req  out  1  to hazard unit: stall F/D, flush E
- wb_en  out  1  register-file write by sequencer
- wb_reg  out  5  write address
- wb_data  out  XLEN  write data

## Operation
- States: IDLE, RUN (unit computing), WB_WAIT (result held, waiting for write port).
- Registers: state, pend_rd[4:0], res[XLEN-1:0], starve_cnt[3:0].
- IDLE:
  - issueE=1 → unit_start=1 (combinational, same cycle), pend_rd←writeregE, →RUN.
  - Otherwise stay in IDLE.
- RUN:
  - unit_done=1 → res←unit_result, starve_cnt←0, →WB_WAIT.
  - If pend_rd=0, → IDLE directly and the result is discarded.
- WB_WAIT:
  - wb_en = !regwriteW; wb_reg=pend_rd; wb_data=res.
  - wb_en=1 → →IDLE.
  - Otherwise starve_cnt saturating +1.
- Active destination act_rd:
  - pend_rd when state≠IDLE.
  - writeregE when state=IDLE and issueE=1.
  - Otherwise none. Active = state≠IDLE or issueE.
- stall_req = Active and any of:
  - RAW: act_rd≠0 and (rsD==act_rd or rtD==act_rd).
  - WAW: act_rd≠0 and regwriteD and writeregD==act_rd.
  - Structural: muldivD (single outstanding op).
  - Forced bubble: state=WB_WAIT and starve_cnt ≥ STARVE_MAX.
- stall_req stays asserted through the wb_en cycle. The D instruction then reads the register file on the following cycle, after the write edge.
- unit_done outside RUN is ignored. issueE outside IDLE cannot occur, because the structural stall prevents it. Ignore it if it appears anyway.
- wb_en is never asserted in the same cycle as regwriteW.

## Timing
- Reset (reset_n=0 at a clock edge) values: state=IDLE, pend_rd=0, res=0, starve_cnt=0; unit_start=0, stall_req=0, wb_en=0, wb_reg=0, wb_data=0. stall_req still reflects the combinational issueE terms.
- Reset mid-operation abandons the op without any write. The unit is reset by the same reset_n.
- Issue to result: unit_start in cycle T; unit_done in cycle T+L (unit latency L).
- Writeback: earliest wb_en is T+L+1, when regwriteW=0 in that cycle.
- Starvation bound: stall_req forced after STARVE_MAX busy cycles. The inserted bubble reaches W within 3 cycles, so wb_en occurs no later than T+L+1+STARVE_MAX+3.
- Back-to-back muldivs: the second waits in D until the cycle after wb_en of the first.
- unit_start is never asserted twice for one instruction. Because flushE bubbles clear issueE, a stalled or flushed E never re-issues.

## Test plan
- Single MUL, writeregE=5, L=8, no W traffic, no D dependency → unit_start at T, stall_req=0 throughout, wb_en=1 at T+9 with wb_reg=5, wb_data=unit_result; state returns to IDLE.
- RAW: D reads rsD=5 while pend_rd=5 → stall_req=1 from issue cycle T through wb_en cycle, 0 the next cycle; D instruction sees the new value.
- WAW: D ALU op writes reg 5 (regwriteD=1) while pend_rd=5 → stall until wb_en; final register 5 value comes from the ALU op.
- Starvation, STARVE_MAX=4, regwriteW=1 continuously after unit_done → wb_en held 0, stall_req rises on the 5th WB_WAIT cycle, wb_en=1 on the first regwriteW=0 cycle, then IDLE.
- Back-to-back muldivs (E issues, muldivD=1, rd different) → second held in D, issued the cycle after the first's wb_en; exactly two unit_start pulses.
- reset_n=0 in RUN with unit_done arriving the next cycle → IDLE, wb_en never asserted, all outputs at reset values; writeregE=0 issue → no wb_en ever.
